// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit 3-sample majority vote,
// one-entry valid/ready holding register, single-cycle frame-error and overrun pulses.
module uart_receiver #(
  parameter int unsigned CLKFREQ  = 100_000_000,
  parameter int unsigned BAUDRATE = 115200
) (
  input  logic       sclk,
  input  logic       rstn,
  input  logic       uartRx,
  output logic [7:0] rxData,
  output logic       rxValid,
  input  logic       rxReady,
  output logic       frameErr,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CPB  = CLKFREQ / BAUDRATE;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned CW   = $clog2(CPB);

  localparam logic [CW-1:0] CntLo   = CW'(HALF - 1);
  localparam logic [CW-1:0] CntMid  = CW'(HALF);
  localparam logic [CW-1:0] CntDec  = CW'(HALF + 1);
  localparam logic [CW-1:0] CntWrap = CW'(CPB - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_t;

  state_t        state;
  logic          s1, s2, s3;
  logic [CW-1:0] cnt;
  logic [1:0]    smp;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;

  logic          fall;
  logic          decide;
  logic          bit_val;
  logic [CW-1:0] cnt_inc;

  // Edge detect, decision strobe, majority vote and wrapping counter increment.
  always_comb begin
    fall    = s3 & ~s2;
    decide  = (cnt == CntDec);
    bit_val = (smp[0] & smp[1]) | (smp[0] & s2) | (smp[1] & s2);
    cnt_inc = (cnt == CntWrap) ? '0 : cnt + 1'b1;
  end

  // Two-stage synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge sclk) begin
    if (!rstn) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= uartRx;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Frame FSM with registered outputs and the holding register.
  always_ff @(posedge sclk) begin
    if (!rstn) begin
      state    <= StIdle;
      cnt      <= '0;
      smp      <= 2'b11;
      shreg    <= '0;
      bit_idx  <= '0;
      rxData   <= '0;
      rxValid  <= 1'b0;
      frameErr <= 1'b0;
      overrun  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      frameErr <= 1'b0;
      overrun  <= 1'b0;
      // Consumer handshake; a delivery in the same cycle overrides this below.
      if (rxValid && rxReady) rxValid <= 1'b0;
      if (cnt == CntLo)  smp[0] <= s2;
      if (cnt == CntMid) smp[1] <= s2;

      unique case (state)
        StIdle: begin
          if (fall) begin
            state <= StStart;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        StStart: begin
          // Counter keeps running into DATA so each bit is decided one period later.
          cnt <= cnt_inc;
          if (decide) begin
            if (bit_val) begin
              state <= StIdle;
              cnt   <= '0;
              busy  <= 1'b0;
            end else begin
              state   <= StData;
              bit_idx <= '0;
            end
          end
        end
        StData: begin
          cnt <= cnt_inc;
          if (decide) begin
            shreg   <= {bit_val, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= StStop;
          end
        end
        StStop: begin
          cnt <= cnt_inc;
          if (decide) begin
            cnt <= '0;
            if (bit_val) begin
              // Leave mid stop bit so a back-to-back start edge is not missed.
              state <= StIdle;
              busy  <= 1'b0;
              if (!rxValid || rxReady) begin
                rxData  <= shreg;
                rxValid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              state    <= StBreak;
              frameErr <= 1'b1;
            end
          end
        end
        StBreak: begin
          // A held-low line stays here instead of being decoded as frames.
          cnt <= '0;
          if (s2) begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= StIdle;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: frame-level scoreboard model checked every cycle,
// directed scenarios, randomized frames/handshakes, and a default-rate instance
// driven at +/-2% baud error.
module tb_uart_receiver;

  localparam int unsigned CLKFREQ  = 1_000_000;
  localparam int unsigned BAUDRATE = 100_000;
  localparam int CPB  = CLKFREQ / BAUDRATE;
  localparam int HALF = CPB / 2;
  // Start bit driven after posedge t0: 2 sync stages + edge register, start decided at
  // HALF+1, nine more bit periods to the stop decision, result registered one edge later.
  localparam int Lat = HALF + 5 + 9 * CPB;

  typedef struct {
    int         t;
    bit         fe;
    logic [7:0] d;
  } ev_s;

  logic       sclk;
  logic       rstn;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  logic       rx2;
  logic [7:0] data2;
  logic       valid2;
  logic       ready2;
  logic       fe2;
  logic       ov2;
  logic       busy2;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         fe_seen = 0;
  int         ov_seen = 0;
  int         fe2_seen = 0;
  int         ov2_seen = 0;
  bit         rdy_rand = 0;

  ev_s        evq[$];
  logic [7:0] acc[$];
  bit         exp_valid = 0;
  logic [7:0] exp_data = '0;
  bit         exp_fe = 0;
  bit         exp_ov = 0;

  uart_receiver #(
    .CLKFREQ (CLKFREQ),
    .BAUDRATE(BAUDRATE)
  ) u_dut (
    .sclk    (sclk),
    .rstn    (rstn),
    .uartRx  (uart_rx),
    .rxData  (rx_data),
    .rxValid (rx_valid),
    .rxReady (rx_ready),
    .frameErr(frame_err),
    .overrun (overrun),
    .busy    (busy)
  );

  uart_receiver u_dut_def (
    .sclk    (sclk),
    .rstn    (rstn),
    .uartRx  (rx2),
    .rxData  (data2),
    .rxValid (valid2),
    .rxReady (ready2),
    .frameErr(fe2),
    .overrun (ov2),
    .busy    (busy2)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard model and per-cycle compare, evaluated 1 time unit after each rising edge.
  always begin : compare
    bit         rdy_e;
    bit         rst_e;
    bit         old_valid;
    bit         loaded;
    logic       prev_valid;
    logic [7:0] prev_data;
    ev_s        ev;
    @(posedge sclk);
    rdy_e      = rx_ready;
    rst_e      = rstn;
    prev_valid = rx_valid;
    prev_data  = rx_data;
    cyc++;
    if (rst_e && prev_valid === 1'b1 && rdy_e) acc.push_back(prev_data);
    #1;
    exp_fe = 0;
    exp_ov = 0;
    if (!rst_e) begin
      exp_valid = 0;
      exp_data  = '0;
      evq.delete();
    end else begin
      old_valid = exp_valid;
      loaded    = 0;
      while (evq.size() > 0 && evq[0].t <= cyc) begin
        ev = evq.pop_front();
        if (ev.t == cyc) begin
          if (ev.fe) begin
            exp_fe = 1;
          end else if (!old_valid || rdy_e) begin
            exp_data  = ev.d;
            exp_valid = 1;
            loaded    = 1;
          end else begin
            exp_ov = 1;
          end
        end
      end
      if (old_valid && rdy_e && !loaded) exp_valid = 0;
    end
    chk("rxValid", rx_valid, exp_valid);
    chk("rxData", rx_data, exp_data);
    chk("frameErr", frame_err, exp_fe);
    chk("overrun", overrun, exp_ov);
    if (frame_err === 1'b1) fe_seen++;
    if (overrun === 1'b1) ov_seen++;
    if (fe2 === 1'b1) fe2_seen++;
    if (ov2 === 1'b1) ov2_seen++;
  end

  // Random consumer back-pressure during the randomized phase.
  always @(negedge sclk) begin
    if (rdy_rand) rx_ready = ($urandom_range(0, 3) == 0);
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge sclk);
  endtask

  task automatic send(input logic [7:0] d, input bit stop_ok, input int glitch_bit);
    logic [9:0] bits;
    ev_s        ev;
    bits = {stop_ok, d, 1'b0};
    ev.t  = cyc + Lat;
    ev.fe = !stop_ok;
    ev.d  = d;
    evq.push_back(ev);
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < CPB; k++) begin
        uart_rx = (b == glitch_bit && k == HALF + 1) ? ~bits[b] : bits[b];
        @(negedge sclk);
      end
    end
  endtask

  // Drives the start bit, data bits 0..3 and half of data bit 4, then stops.
  task automatic send_partial(input logic [7:0] d);
    logic [9:0] bits;
    bits = {1'b1, d, 1'b0};
    for (int i = 0; i < 5 * CPB + HALF; i++) begin
      uart_rx = bits[i / CPB];
      @(negedge sclk);
    end
  endtask

  task automatic send_def(input logic [7:0] d, input int period);
    logic [9:0] bits;
    bits = {1'b1, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx2 = bits[b];
      repeat (period) @(negedge sclk);
    end
    rx2 = 1'b1;
  endtask

  initial begin : stim
    int         fe0;
    int         ov0;
    int         na;
    logic [7:0] d;
    rstn     = 1'b0;
    uart_rx  = 1'b1;
    rx_ready = 1'b0;
    rx2      = 1'b1;
    ready2   = 1'b0;
    repeat (3) @(negedge sclk);
    rstn = 1'b1;
    chk("reset busy", busy, 1'b0);
    chk("reset rxValid", rx_valid, 1'b0);
    chk("reset rxData", rx_data, 8'h00);
    idle(2 * CPB);

    // 1: single byte held, then one-cycle handshake.
    fe0 = fe_seen;
    ov0 = ov_seen;
    send(8'hA5, 1'b1, -1);
    idle(4);
    chk("t1 rxValid", rx_valid, 1'b1);
    chk("t1 rxData", rx_data, 8'hA5);
    chk("t1 busy", busy, 1'b0);
    rx_ready = 1'b1;
    @(negedge sclk);
    rx_ready = 1'b0;
    chk("t1 valid after ack", rx_valid, 1'b0);
    chk("t1 no pulses", (fe_seen - fe0) + (ov_seen - ov0), 0);

    // 2: back-to-back frames with the consumer always ready.
    idle(CPB);
    rx_ready = 1'b1;
    na  = acc.size();
    ov0 = ov_seen;
    send(8'h00, 1'b1, -1);
    send(8'hFF, 1'b1, -1);
    idle(6);
    chk("t2 deliveries", acc.size() - na, 2);
    if (acc.size() >= na + 2) begin
      chk("t2 first", acc[na], 8'h00);
      chk("t2 second", acc[na+1], 8'hFF);
    end
    chk("t2 no overrun", ov_seen - ov0, 0);

    // 3: second byte overruns a full holding register.
    rx_ready = 1'b0;
    idle(CPB);
    ov0 = ov_seen;
    send(8'h3C, 1'b1, -1);
    send(8'h7E, 1'b1, -1);
    idle(6);
    chk("t3 rxData kept", rx_data, 8'h3C);
    chk("t3 rxValid", rx_valid, 1'b1);
    chk("t3 one overrun", ov_seen - ov0, 1);
    rx_ready = 1'b1;
    @(negedge sclk);
    rx_ready = 1'b0;

    // 4: low stop bit, then a long break.
    idle(CPB);
    fe0 = fe_seen;
    send(8'h55, 1'b0, -1);
    repeat (50 * CPB) @(negedge sclk);
    chk("t4 busy in break", busy, 1'b1);
    chk("t4 one frameErr", fe_seen - fe0, 1);
    chk("t4 rxValid", rx_valid, 1'b0);
    idle(5);
    chk("t4 busy after release", busy, 1'b0);
    idle(2 * CPB);
    rx_ready = 1'b1;
    na = acc.size();
    send(8'h12, 1'b1, -1);
    idle(6);
    chk("t4 next byte count", acc.size() - na, 1);
    if (acc.size() > na) chk("t4 next byte", acc[na], 8'h12);

    // 5: glitch on idle line, then a data-bit midpoint glitch.
    rx_ready = 1'b0;
    fe0 = fe_seen;
    ov0 = ov_seen;
    uart_rx = 1'b0;
    repeat (3) @(negedge sclk);
    idle(2 * CPB);
    chk("t5 busy", busy, 1'b0);
    chk("t5 rxValid", rx_valid, 1'b0);
    chk("t5 no pulses", (fe_seen - fe0) + (ov_seen - ov0), 0);
    send(8'h96, 1'b1, 4);
    idle(4);
    chk("t5 outvoted byte", rx_data, 8'h96);
    rx_ready = 1'b1;
    @(negedge sclk);
    rx_ready = 1'b0;

    // 6: reset in the middle of bit 4 while a byte is held.
    idle(CPB);
    send(8'h81, 1'b1, -1);
    idle(3);
    send_partial(8'h6D);
    rstn = 1'b0;
    @(negedge sclk);
    rstn    = 1'b1;
    uart_rx = 1'b1;
    chk("t6 busy", busy, 1'b0);
    chk("t6 rxValid", rx_valid, 1'b0);
    chk("t6 rxData", rx_data, 8'h00);
    idle(3 * CPB);
    rx_ready = 1'b1;
    na = acc.size();
    send(8'hC3, 1'b1, -1);
    idle(6);
    chk("t6 after reset count", acc.size() - na, 1);
    if (acc.size() > na) chk("t6 after reset byte", acc[na], 8'hC3);

    // Randomized frames, gaps, glitches and consumer back-pressure.
    rdy_rand = 1;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom_range(0, 255));
      send(d, 1'b1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1);
      idle(($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 25)));
    end
    idle(Lat + 10);
    rdy_rand = 0;
    @(negedge sclk);
    rx_ready = 1'b0;
    idle(2);

    // Default rate (CPB=868), transmitter 2% fast then 2% slow.
    send_def(8'h5A, 851);
    repeat (CPB) @(negedge sclk);
    chk("def fast rxValid", valid2, 1'b1);
    chk("def fast rxData", data2, 8'h5A);
    ready2 = 1'b1;
    @(negedge sclk);
    ready2 = 1'b0;
    chk("def ack", valid2, 1'b0);
    repeat (50) @(negedge sclk);
    send_def(8'h5A, 886);
    repeat (CPB) @(negedge sclk);
    chk("def slow rxValid", valid2, 1'b1);
    chk("def slow rxData", data2, 8'h5A);
    chk("def no pulses", fe2_seen + ov2_seen, 0);
    chk("def busy", busy2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
